// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has priority, and a one-entry
// buffer parks a long-latency result until a free slot, a WAW squash, or a forced drain.
module rf_write_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned WAIT_W   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    input  logic        lu_valid,
    input  logic [2:0]  lu_addr,
    input  logic [15:0] lu_data,
    output logic        lu_ready,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        stall_wb,
    output logic        pend_valid,
    output logic [2:0]  pend_addr
);

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 16;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_FORCE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     buf_addr_q, buf_addr_d;
    logic [DW-1:0]     buf_data_q, buf_data_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    // Next-state and write-port steering; every output is held at zero while rst is high.
    always_comb begin
        state_d    = state_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        wait_d     = wait_q;
        lu_ready   = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        stall_wb   = 1'b0;
        pend_valid = 1'b0;
        pend_addr  = '0;

        if (!rst) begin
            unique case (state_q)
                S_IDLE: begin
                    lu_ready = 1'b1;
                    if (wb_en) begin
                        rf_we    = 1'b1;
                        rf_waddr = wb_addr;
                        rf_wdata = wb_data;
                    end
                    // Accepted results are only written from a later cycle (no bypass).
                    if (lu_valid) begin
                        buf_addr_d = lu_addr;
                        buf_data_d = lu_data;
                        wait_d     = '0;
                        state_d    = S_PEND;
                    end
                end
                S_PEND: begin
                    pend_valid = 1'b1;
                    pend_addr  = buf_addr_q;
                    rf_we      = 1'b1;
                    if (!wb_en) begin
                        rf_waddr = buf_addr_q;
                        rf_wdata = buf_data_q;
                        state_d  = S_IDLE;
                    end else begin
                        rf_waddr = wb_addr;
                        rf_wdata = wb_data;
                        // A younger pipeline write to the same register makes the buffer dead.
                        if (wb_addr == buf_addr_q) begin
                            state_d = S_IDLE;
                        end else if (wait_q == WAIT_LAST) begin
                            state_d = S_FORCE;
                        end else begin
                            wait_d = wait_q + WAIT_W'(1);
                        end
                    end
                end
                S_FORCE: begin
                    stall_wb   = 1'b1;
                    pend_valid = 1'b1;
                    pend_addr  = buf_addr_q;
                    rf_we      = 1'b1;
                    rf_waddr   = buf_addr_q;
                    rf_wdata   = buf_data_q;
                    state_d    = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            wait_q     <= wait_d;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: each driven cycle queues its expected outputs,
// which are popped and compared on the following falling edge.
module tb_rf_write_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        lu_valid;
    logic [2:0]  lu_addr;
    logic [15:0] lu_data;
    logic        lu_ready;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        stall_wb;
    logic        pend_valid;
    logic [2:0]  pend_addr;

    rf_write_arbiter #(.MAX_WAIT(4), .WAIT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .lu_valid   (lu_valid),
        .lu_addr    (lu_addr),
        .lu_data    (lu_data),
        .lu_ready   (lu_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .stall_wb   (stall_wb),
        .pend_valid (pend_valid),
        .pend_addr  (pend_addr)
    );

    typedef struct {
        string       tag;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        st;
        logic        rdy;
        logic        pv;
        logic [2:0]  pa;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_chk  = 0;
    int   n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Drive one cycle of stimulus and queue the outputs expected during that cycle.
    task automatic cyc(input string tag, input logic r,
                       input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic lv, input logic [2:0] la, input logic [15:0] ld,
                       input logic e_we, input logic [2:0] e_wa, input logic [15:0] e_wd,
                       input logic e_st, input logic e_rdy, input logic e_pv, input logic [2:0] e_pa);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; wb_en = we; wb_addr = wa; wb_data = wd;
        lu_valid = lv; lu_addr = la; lu_data = ld;
        e.tag = tag; e.we = e_we; e.wa = e_wa; e.wd = e_wd;
        e.st = e_st; e.rdy = e_rdy; e.pv = e_pv; e.pa = e_pa;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            chk({cur.tag, ".rf_we"},      32'(rf_we),      32'(cur.we));
            chk({cur.tag, ".rf_waddr"},   32'(rf_waddr),   32'(cur.wa));
            chk({cur.tag, ".rf_wdata"},   32'(rf_wdata),   32'(cur.wd));
            chk({cur.tag, ".stall_wb"},   32'(stall_wb),   32'(cur.st));
            chk({cur.tag, ".lu_ready"},   32'(lu_ready),   32'(cur.rdy));
            chk({cur.tag, ".pend_valid"}, 32'(pend_valid), 32'(cur.pv));
            chk({cur.tag, ".pend_addr"},  32'(pend_addr),  32'(cur.pa));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        lu_valid = 1'b0; lu_addr = '0; lu_data = '0;

        // Reset gates every output even with live requests.
        cyc("rst0", 1, 1, 3'd3, 16'h1234, 1, 3'd5, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0);
        cyc("rst1", 1, 1, 3'd3, 16'h1234, 1, 3'd5, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0);

        cyc("pipe", 0, 1, 3'd3, 16'h1234, 0, 3'd0, 16'h0, 1, 3'd3, 16'h1234, 0, 1, 0, 0);

        // Idle-slot drain.
        cyc("drain_acc", 0, 0, 3'd0, 16'h0, 1, 3'd5, 16'hBEEF, 0, 0, 0, 0, 1, 0, 0);
        cyc("drain_wr",  0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1, 3'd5, 16'hBEEF, 0, 0, 1, 3'd5);
        cyc("drain_idl", 0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 0, 0, 0, 1, 0, 0);

        // Starvation: four lost cycles, then FORCE; lu_valid while full must be ignored.
        cyc("starve_acc", 0, 0, 3'd0, 16'h0, 1, 3'd2, 16'h00AA, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 4; i++)
            cyc($sformatf("starve_c%0d", i), 0, 1, 3'd1, 16'h1000 + 16'(i), 1, 3'd6, 16'h9999,
                1, 3'd1, 16'h1000 + 16'(i), 0, 0, 1, 3'd2);
        cyc("starve_force",  0, 1, 3'd1, 16'h5555, 0, 3'd0, 16'h0, 1, 3'd2, 16'h00AA, 1, 0, 1, 3'd2);
        cyc("starve_replay", 0, 1, 3'd1, 16'h5555, 0, 3'd0, 16'h0, 1, 3'd1, 16'h5555, 0, 1, 0, 0);
        cyc("starve_idle",   0, 0, 3'd0, 16'h0,    0, 3'd0, 16'h0, 0, 0, 0, 0, 1, 0, 0);

        // WAW squash.
        cyc("waw_acc",  0, 0, 3'd0, 16'h0,    1, 3'd4, 16'h4444, 0, 0, 0, 0, 1, 0, 0);
        cyc("waw_hit",  0, 1, 3'd4, 16'h7777, 0, 3'd0, 16'h0, 1, 3'd4, 16'h7777, 0, 0, 1, 3'd4);
        cyc("waw_idle", 0, 0, 3'd0, 16'h0,    0, 3'd0, 16'h0, 0, 0, 0, 0, 1, 0, 0);

        // Reset asserted in the FORCE cycle drops the buffered result.
        cyc("rstf_acc", 0, 0, 3'd0, 16'h0, 1, 3'd6, 16'h6666, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 4; i++)
            cyc($sformatf("rstf_c%0d", i), 0, 1, 3'd1, 16'h2000 + 16'(i), 0, 3'd0, 16'h0,
                1, 3'd1, 16'h2000 + 16'(i), 0, 0, 1, 3'd6);
        cyc("rstf_force", 1, 1, 3'd1, 16'h2005, 0, 3'd0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
        cyc("rstf_post0", 0, 0, 3'd0, 16'h0,    0, 3'd0, 16'h0, 0, 0, 0, 0, 1, 0, 0);
        cyc("rstf_post1", 0, 0, 3'd0, 16'h0,    0, 3'd0, 16'h0, 0, 0, 0, 0, 1, 0, 0);

        // Back-to-back long-latency results with lu_valid held high.
        cyc("b2b_0", 0, 0, 3'd0, 16'h0, 1, 3'd1, 16'hA001, 0, 0, 0, 0, 1, 0, 0);
        cyc("b2b_1", 0, 0, 3'd0, 16'h0, 1, 3'd2, 16'hA002, 1, 3'd1, 16'hA001, 0, 0, 1, 3'd1);
        cyc("b2b_2", 0, 0, 3'd0, 16'h0, 1, 3'd3, 16'hA003, 0, 0, 0, 0, 1, 0, 0);
        cyc("b2b_3", 0, 0, 3'd0, 16'h0, 1, 3'd4, 16'hA004, 1, 3'd3, 16'hA003, 0, 0, 1, 3'd3);
        cyc("b2b_4", 0, 0, 3'd0, 16'h0, 1, 3'd5, 16'hA005, 0, 0, 0, 0, 1, 0, 0);
        cyc("b2b_5", 0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0,    1, 3'd5, 16'hA005, 0, 0, 1, 3'd5);
        cyc("b2b_6", 0, 0, 3'd0, 16'h0, 0, 3'd0, 16'h0,    0, 0, 0, 0, 1, 0, 0);

        // Wait counter restarts on each accept; accept coincides with a pipeline write.
        cyc("cnt_acc", 0, 0, 3'd0, 16'h0, 1, 3'd2, 16'h0B0B, 0, 0, 0, 0, 1, 0, 0);
        cyc("cnt_l1",  0, 1, 3'd3, 16'h3001, 0, 3'd0, 16'h0, 1, 3'd3, 16'h3001, 0, 0, 1, 3'd2);
        cyc("cnt_l2",  0, 1, 3'd3, 16'h3002, 0, 3'd0, 16'h0, 1, 3'd3, 16'h3002, 0, 0, 1, 3'd2);
        cyc("cnt_drn", 0, 0, 3'd0, 16'h0,    0, 3'd0, 16'h0, 1, 3'd2, 16'h0B0B, 0, 0, 1, 3'd2);
        cyc("cnt_acc2", 0, 1, 3'd7, 16'h7070, 1, 3'd5, 16'h0C0C, 1, 3'd7, 16'h7070, 0, 1, 0, 0);
        for (int i = 1; i <= 4; i++)
            cyc($sformatf("cnt_w%0d", i), 0, 1, 3'd3, 16'h4000 + 16'(i), 0, 3'd0, 16'h0,
                1, 3'd3, 16'h4000 + 16'(i), 0, 0, 1, 3'd5);
        cyc("cnt_force", 0, 1, 3'd3, 16'h4005, 0, 3'd0, 16'h0, 1, 3'd5, 16'h0C0C, 1, 0, 1, 3'd5);
        cyc("cnt_idle",  0, 0, 3'd0, 16'h0,    0, 3'd0, 16'h0, 0, 0, 0, 0, 1, 0, 0);

        @(posedge clk);
        @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port between the pipeline writeback (post MEM/WB, MemToReg already resolved) and a long-latency unit (multiply/divide) that returns results out of band. The pipeline has priority. A one-entry holding buffer parks the long-latency result. A wait counter bounds starvation by stalling the pipeline for one cycle to drain the buffer. The block sits between the MEM/WB stage, the long-latency unit and the register file write port, and exports the pending destination to the hazard unit.

## Interface
- MAX_WAIT, 4, pipeline-won cycles tolerated while the buffer is full before a forced drain (≥1)
- WAIT_W, 3, wait counter width; must hold MAX_WAIT-1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- wb_en  in  1  pipeline write request (RegWrite from MEM/WB)
- wb_addr  in  3  pipeline destination register
- wb_data  in  16  pipeline write data
- lu_valid  in  1  long-latency result valid
- lu_addr  in  3  long-latency destination register
- lu_data  in  16  long-latency result
- lu_ready  out  1  buffer empty, result accepted on lu_valid & lu_ready
- rf_we  out  1  register file write enable
- rf_waddr  out  3  register file write address
- rf_wdata  out  16  register file write data
- stall_wb  out  1  pipeline must hold MEM/WB and all earlier stages this cycle
- pend_valid  out  1  buffer holds an unwritten result
- pend_addr  out  3  destination of buffered result (0 when empty)

## Operation
- Registered state: FSM {IDLE, PEND, FORCE}, buffer (addr 3, data 16), wait counter WAIT_W.
- Outputs are combinational from state and inputs. The register file samples rf_* on the rising edge.
- rf_waddr and rf_wdata are 0 whenever rf_we=0.

**IDLE (buffer empty)**
- lu_ready=1; rf_* = pipeline request.
- lu_valid=1: capture lu_addr/lu_data, counter←0, go to PEND.
- No same-cycle bypass: a long-latency result is never written in its accept cycle.

**PEND (buffer full)**
- lu_ready=0; pend_valid=1.
- wb_en=0: rf_* drives the buffer, go to IDLE.
- wb_en=1 and wb_addr==pend_addr (WAW squash): pipeline writes, buffer discarded without a write, go to IDLE.
- wb_en=1 and addresses differ: pipeline writes.
  - If counter==MAX_WAIT-1, go to FORCE.
  - Otherwise counter++.

**FORCE**
- stall_wb=1; rf_* drives the buffer; wb_en is ignored.
- The held MEM/WB instruction replays next cycle.
- Go to IDLE.

**Reset**
- While rst=1: rf_we=0, rf_waddr=0, rf_wdata=0, lu_ready=0, stall_wb=0, pend_valid=0, pend_addr=0.
- On the clock edge: state←IDLE, counter←0, buffer cleared.
- Reset mid-PEND/FORCE drops the buffered result with no write.

## Timing
- Accept at edge N. Earliest register-file write is cycle N+1, when the pipeline is idle.
- Worst case: MAX_WAIT lost cycles, then FORCE in cycle N+MAX_WAIT+1.
- lu_ready rises the cycle after the drain or squash. Maximum back-to-back throughput is one long-latency result per 2 cycles.
- stall_wb is asserted for exactly one cycle per FORCE and never in IDLE/PEND.
- Pipeline write latency is zero: rf_we follows wb_en in the same cycle whenever state≠FORCE.

## Test plan
- **Pipeline-only:** wb_en=1, wb_addr=3, wb_data=16'h1234, lu_valid=0 → rf_we=1, rf_waddr=3, rf_wdata=16'h1234 same cycle; stall_wb=0; lu_ready=1.
- **Idle-slot drain:** lu_valid=1, lu_addr=5, lu_data=16'hBEEF accepted in cycle 0, wb_en=0 in cycle 1 → cycle 1: rf_we=1, rf_waddr=5, rf_wdata=16'hBEEF, pend_valid=1. Cycle 2: lu_ready=1, pend_valid=0.
- **Starvation, MAX_WAIT=4:** accept lu (addr 2, 16'h00AA) in cycle 0; wb_en=1, wb_addr=1 continuously → cycles 1–4 write pipeline data; cycle 5: stall_wb=1, rf_waddr=2, rf_wdata=16'h00AA; cycle 6: stall_wb=0, lu_ready=1.
- **WAW squash:** buffer holds addr 4; pipeline wb_en=1, wb_addr=4, wb_data=16'h7777 → rf writes 16'h7777 to r4, buffer never written, pend_valid=0 next cycle.
- **Reset mid-operation:** assert rst in the FORCE cycle → rf_we=0, stall_wb=0 that cycle; after release: IDLE, lu_ready=1, no write of the dropped result.
- **Back-to-back lu:** lu_valid held high with wb_en=0 → accepts in cycles 0, 2, 4; writes in cycles 1, 3, 5; lu_ready toggles 1,0,1,0.
